puf_challenge_ctrl: RTL
=======================

PUF_CHALLENGE_CTRL -- requirements
Module: puf_challenge_ctrl

Interface
REQ-001 The block SHALL have these parameters: N, default 128, challenge width (matches the arbiter delay-chain length); RESP_BITS, default 32, response bits per request; SETTLE, default 16, cycles per arm/fire phase (minimum 1); SEED_INIT, default 128'h1, LFSR reset value (nonzero).
REQ-002 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-003 The block SHALL have these ports, one per line:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request one RESP_BITS-bit response
- seed_valid  in  1  load seed into the LFSR
- seed  in  N  challenge seed
- challenge  out  N  challenge vector to the arbiter control bus
- race  out  1  launch edge, driven to both arbiter race inputs
- puf_out  in  1  arbiter response bit
- busy  out  1  high in any state except IDLE
- resp_valid  out  1  response available
- response  out  RESP_BITS  collected response, bit 0 = first challenge
- resp_ready  in  1  consumer accepts response

Function
REQ-004 The block SHALL implement the FSM states IDLE, LOAD, ARM, FIRE, SAMPLE and DONE.
REQ-005 challenge SHALL equal the current LFSR state in every state and SHALL change only on a seed load or in SAMPLE.
REQ-006 LFSR SHALL be Fibonacci with fb = c[127]^c[125]^c[100]^c[98] (taps scaled identically for N=128 only), and SHALL advance as c <= {c[N-2:0], fb} on the cycle leaving SAMPLE.
REQ-007 In IDLE, seed_valid SHALL load the LFSR with seed; an all-zero seed SHALL load SEED_INIT instead.
REQ-008 In IDLE with start=1 and seed_valid=0, the block SHALL clear the bit index and response, and go to LOAD on the next cycle.
REQ-009 If seed_valid and start are both high in IDLE, the seed SHALL load and start SHALL be ignored.
REQ-010 start and seed_valid SHALL be ignored outside IDLE.
REQ-011 LOAD SHALL last 1 cycle with race=0, then the FSM SHALL go to ARM.
REQ-012 ARM SHALL last exactly SETTLE cycles with race=0 and challenge stable, then the FSM SHALL go to FIRE.
REQ-013 FIRE SHALL last exactly SETTLE cycles with race=1, then the FSM SHALL go to SAMPLE.
REQ-014 SAMPLE SHALL last 1 cycle with race=1, capture response[idx] <= puf_out, advance the LFSR and increment idx.
REQ-015 After SAMPLE, the FSM SHALL go to LOAD if idx < RESP_BITS-1, otherwise to DONE.
REQ-016 Each bit SHALL take 2*SETTLE+2 cycles.
REQ-017 With start sampled at cycle 0, resp_valid SHALL first be 1 at cycle 1 + RESP_BITS*(2*SETTLE+2).
REQ-018 race SHALL be registered and glitch-free, and SHALL be 1 only in FIRE and SAMPLE.
REQ-019 In DONE, resp_valid SHALL be 1 and response SHALL be held stable until resp_valid&resp_ready.
REQ-020 On that handshake cycle, the FSM SHALL go to IDLE and resp_valid SHALL drop the next cycle.
REQ-021 resp_ready SHALL be ignored outside DONE.
REQ-022 The response SHALL remain readable in IDLE until the next accepted start.
REQ-023 The bit index SHALL be ceil(log2(RESP_BITS+1)) bits wide and SHALL NOT wrap within a request.
REQ-024 The phase counter SHALL count 0..SETTLE-1 and SHALL reload on every phase entry.

Reset
REQ-025 When rst=1 at a clk edge, the block SHALL set state=IDLE, LFSR=SEED_INIT, race=0, busy=0, resp_valid=0, response=0, idx=0 and phase counter=0.
REQ-026 Reset SHALL take priority over all other inputs, including mid-FIRE and DONE.
REQ-027 A request interrupted by reset SHALL be discarded without asserting resp_valid.

Verification
REQ-028 The bench SHALL cover the following directed scenarios (N=128, RESP_BITS=4, SETTLE=2):
- Reset, then idle -> challenge=128'h1, race=0, busy=0, resp_valid=0.
- start pulse at cycle 0 with puf_out tied 1 -> race high for 3 cycles per bit, 4 race pulses, resp_valid at cycle 25, response=4'hF.
- puf_out driven 1,0,1,1 at the four SAMPLE cycles -> response=4'b1101; challenge takes 4 successive LFSR values from SEED_INIT.
- seed_valid with seed=0 -> LFSR=SEED_INIT; seed_valid with start in the same cycle -> seed loaded, busy stays 0.
- DONE with resp_ready=0 for 10 cycles, then 1 -> resp_valid and response stable for 10 cycles, IDLE one cycle after the handshake; start during DONE is ignored.
- rst asserted mid-FIRE of bit 2 -> next cycle race=0, state=IDLE, response=0, no resp_valid.

Source files
------------

// File: rtl/puf_challenge_ctrl.sv
// Arbiter-PUF challenge sequencer: drives LFSR challenges, launches a race per bit
// and assembles the sampled arbiter outputs into one RESP_BITS-bit response.
`timescale 1ns/1ps
module puf_challenge_ctrl #(
    parameter int             N         = 128,
    parameter int             RESP_BITS = 32,
    parameter int             SETTLE    = 16,
    parameter logic [N-1:0]   SEED_INIT = N'(1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 seed_valid,
    input  logic [N-1:0]         seed,
    output logic [N-1:0]         challenge,
    output logic                 race,
    input  logic                 puf_out,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [RESP_BITS-1:0] response,
    input  logic                 resp_ready
);
    localparam int IW = $clog2(RESP_BITS + 1);
    localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // Tap positions are the 128-bit polynomial scaled to N.
    localparam int T0 = N - 1;
    localparam int T1 = N - 3;
    localparam int T2 = (100 * N) / 128;
    localparam int T3 = (98 * N) / 128;

    typedef enum logic [2:0] {IDLE, LOAD, ARM, FIRE, SAMPLE, DONE} state_t;

    state_t               state_reg, state_next;
    logic [N-1:0]         lfsr_reg, lfsr_next;
    logic [PW-1:0]        phase_reg, phase_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic [RESP_BITS-1:0] resp_reg, resp_next;
    logic                 race_reg, busy_reg, valid_reg;
    logic                 resp_clear;
    logic                 fb;
    logic                 phase_last;

    assign fb         = lfsr_reg[T0] ^ lfsr_reg[T1] ^ lfsr_reg[T2] ^ lfsr_reg[T3];
    assign phase_last = (phase_reg == PW'(SETTLE - 1));

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        idx_next   = idx_reg;
        lfsr_next  = lfsr_reg;
        resp_clear = 1'b0;
        case (state_reg)
            IDLE: begin
                if (seed_valid) begin
                    lfsr_next = (seed == '0) ? SEED_INIT : seed;
                end else if (start) begin
                    resp_clear = 1'b1;
                    idx_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                phase_next = '0;
                state_next = ARM;
            end
            ARM: begin
                if (phase_last) begin
                    phase_next = '0;
                    state_next = FIRE;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            FIRE: begin
                if (phase_last) begin
                    phase_next = '0;
                    state_next = SAMPLE;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            SAMPLE: begin
                lfsr_next  = {lfsr_reg[N-2:0], fb};
                idx_next   = idx_reg + 1'b1;
                state_next = (idx_reg < IW'(RESP_BITS - 1)) ? LOAD : DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Each response bit has its own capture mux, selected by the current bit index.
    genvar gi;
    generate
        for (gi = 0; gi < RESP_BITS; gi++) begin : g_resp
            assign resp_next[gi] = resp_clear ? 1'b0 :
                                   ((state_reg == SAMPLE) && (idx_reg == IW'(gi))) ? puf_out :
                                   resp_reg[gi];
        end
    endgenerate

    // Outputs are registered from the next state so race never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            lfsr_reg  <= SEED_INIT;
            phase_reg <= '0;
            idx_reg   <= '0;
            resp_reg  <= '0;
            race_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            phase_reg <= phase_next;
            idx_reg   <= idx_next;
            resp_reg  <= resp_next;
            race_reg  <= (state_next == FIRE) || (state_next == SAMPLE);
            busy_reg  <= (state_next != IDLE);
            valid_reg <= (state_next == DONE);
        end
    end

    assign challenge  = lfsr_reg;
    assign race       = race_reg;
    assign busy       = busy_reg;
    assign resp_valid = valid_reg;
    assign response   = resp_reg;
endmodule
